// File: rtl/lsu_mem_arbiter_pkg.sv
// Shared types for the LSU memory arbiter: FSM states, the memory request
// struct used by both lanes and the pending buffer, and the lane count.
package lsu_mem_arbiter_pkg;

    localparam int ARB_NUM_LANES = 2;
    localparam int ARB_ADDR_W    = 32;
    localparam int ARB_DATA_W    = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/lsu_mem_arbiter_pending_buf.sv
// One-entry holding register for the lane-1 request deferred behind a
// same-cycle lane-0 request.
module arb_pending_buf
    import lsu_mem_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  logic     clear,
    input  mem_req_t din,
    output mem_req_t dout,
    output logic     valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Two-lane load/store arbiter for a single-port data memory, issuing same-cycle
// pairs in program order. Optional perf counters under ARB_PERF_CNT_EN.
module lsu_mem_arbiter
    import lsu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic              req_we_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_wdata_0,
    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic              req_we_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              rsp_valid_0,
    output logic [DATA_W-1:0] rsp_rdata_0,
    output logic              rsp_valid_1,
    output logic [DATA_W-1:0] rsp_rdata_1,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       conflict_cnt,
    output logic [31:0]       flush_drop_cnt,
`endif
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t               state;
    arb_state_t               next_state;
    mem_req_t                 lane0_req;
    mem_req_t                 lane1_req;
    mem_req_t                 pend_req;
    mem_req_t                 sel_req;
    logic                     pend_valid;
    logic                     buf_load;
    logic                     buf_clear;
    logic [ARB_NUM_LANES-1:0] issue_oh;
    logic                     issue_any;

    assign lane0_req = '{we: req_we_0, addr: req_addr_0, wdata: req_wdata_0};
    assign lane1_req = '{we: req_we_1, addr: req_addr_1, wdata: req_wdata_1};

    arb_pending_buf u_pending_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (buf_load),
        .clear (buf_clear),
        .din   (lane1_req),
        .dout  (pend_req),
        .valid (pend_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Issue is gated by reset so the memory port is quiet while rst is low.
    always_comb begin
        next_state  = state;
        issue_oh    = '0;
        sel_req     = '0;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        if (rst) begin
            unique case (state)
                ARB_IDLE: begin
                    if (!flush) begin
                        req_ready_0 = 1'b1;
                        req_ready_1 = 1'b1;
                        if (req_valid_0) begin
                            issue_oh[0] = 1'b1;
                            sel_req     = lane0_req;
                            if (req_valid_1) begin
                                buf_load   = 1'b1;
                                next_state = ARB_HOLD;
                            end
                        end else if (req_valid_1) begin
                            issue_oh[1] = 1'b1;
                            sel_req     = lane1_req;
                        end
                    end
                end
                ARB_HOLD: begin
                    buf_clear  = 1'b1;
                    next_state = ARB_IDLE;
                    if (!flush && pend_valid) begin
                        issue_oh[1] = 1'b1;
                        sel_req     = pend_req;
                    end
                end
                default: next_state = ARB_IDLE;
            endcase
        end
    end

    assign issue_any    = |issue_oh;
    assign mem_read_en  = issue_any && !sel_req.we;
    assign mem_write_en = issue_any && sel_req.we;
    assign mem_addr     = sel_req.addr;
    assign mem_wdata    = sel_req.wdata;

    // Stores answer with zero data; rdata holds between responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_0 <= 1'b0;
            rsp_rdata_0 <= '0;
            rsp_valid_1 <= 1'b0;
            rsp_rdata_1 <= '0;
        end else begin
            rsp_valid_0 <= issue_oh[0];
            rsp_valid_1 <= issue_oh[1];
            if (issue_oh[0]) begin
                rsp_rdata_0 <= sel_req.we ? '0 : mem_rdata;
            end
            if (issue_oh[1]) begin
                rsp_rdata_1 <= sel_req.we ? '0 : mem_rdata;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt   <= '0;
            flush_drop_cnt <= '0;
        end else begin
            if (state == ARB_IDLE && req_valid_0 && req_valid_1) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
            if (state == ARB_HOLD && flush && pend_valid) begin
                flush_drop_cnt <= flush_drop_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Self-checking bench for lsu_mem_arbiter: a queue-based program-order model
// checked every cycle, plus directed literal expectations.
module tb_lsu_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid_0, req_ready_0, req_we_0;
    logic [31:0] req_addr_0, req_wdata_0;
    logic        req_valid_1, req_ready_1, req_we_1;
    logic [31:0] req_addr_1, req_wdata_1;
    logic        rsp_valid_0, rsp_valid_1;
    logic [31:0] rsp_rdata_0, rsp_rdata_1;
    logic        mem_read_en, mem_write_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt, flush_drop_cnt;
`endif

    int passed = 0;
    int total  = 0;

    lsu_mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .req_valid_0    (req_valid_0),
        .req_ready_0    (req_ready_0),
        .req_we_0       (req_we_0),
        .req_addr_0     (req_addr_0),
        .req_wdata_0    (req_wdata_0),
        .req_valid_1    (req_valid_1),
        .req_ready_1    (req_ready_1),
        .req_we_1       (req_we_1),
        .req_addr_1     (req_addr_1),
        .req_wdata_1    (req_wdata_1),
        .rsp_valid_0    (rsp_valid_0),
        .rsp_rdata_0    (rsp_rdata_0),
        .rsp_valid_1    (rsp_valid_1),
        .rsp_rdata_1    (rsp_rdata_1),
`ifdef ARB_PERF_CNT_EN
        .conflict_cnt   (conflict_cnt),
        .flush_drop_cnt (flush_drop_cnt),
`endif
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory: combinational read, write at the issue edge.
    logic [31:0] env_mem [0:255];
    assign mem_rdata = env_mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_write_en) env_mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Reference model: a program-order queue of accepted accesses drained one per cycle.
    typedef struct {
        int          lane;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t        sched[$];
    acc_t        acc;
    logic [31:0] model_mem [0:255];
    logic        exp_v0, exp_v1, have, idle;
    logic [31:0] exp_rd0, exp_rd1;
    int          exp_conf, exp_drop;

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("rst_rsp_valid_0", 32'(rsp_valid_0), 32'h0);
            checkOutput("rst_rsp_rdata_0", rsp_rdata_0, 32'h0);
            checkOutput("rst_rsp_valid_1", 32'(rsp_valid_1), 32'h0);
            checkOutput("rst_rsp_rdata_1", rsp_rdata_1, 32'h0);
            checkOutput("rst_mem_en", {30'h0, mem_read_en, mem_write_en}, 32'h0);
            checkOutput("rst_mem_addr", mem_addr, 32'h0);
            sched.delete();
            exp_v0 = 0; exp_v1 = 0; exp_rd0 = 0; exp_rd1 = 0;
            exp_conf = 0; exp_drop = 0;
        end else begin
            checkOutput("rsp_valid_0", 32'(rsp_valid_0), 32'(exp_v0));
            checkOutput("rsp_rdata_0", rsp_rdata_0, exp_rd0);
            checkOutput("rsp_valid_1", 32'(rsp_valid_1), 32'(exp_v1));
            checkOutput("rsp_rdata_1", rsp_rdata_1, exp_rd1);
`ifdef ARB_PERF_CNT_EN
            checkOutput("conflict_cnt", conflict_cnt, 32'(exp_conf));
            checkOutput("flush_drop_cnt", flush_drop_cnt, 32'(exp_drop));
`endif
            idle = (sched.size() == 0);
            checkOutput("req_ready_0", 32'(req_ready_0), 32'(idle && !flush));
            checkOutput("req_ready_1", 32'(req_ready_1), 32'(idle && !flush));
            if (idle && req_valid_0 && req_valid_1) exp_conf++;
            if (flush) begin
                if (!idle) exp_drop++;
                sched.delete();
            end else if (idle) begin
                if (req_valid_0) sched.push_back('{0, req_we_0, req_addr_0, req_wdata_0});
                if (req_valid_1) sched.push_back('{1, req_we_1, req_addr_1, req_wdata_1});
            end
            have = 0;
            if (!flush && sched.size() > 0) begin
                acc  = sched.pop_front();
                have = 1;
            end
            checkOutput("mem_read_en", 32'(mem_read_en), 32'(have && !acc.we));
            checkOutput("mem_write_en", 32'(mem_write_en), 32'(have && acc.we));
            checkOutput("mem_addr", mem_addr, have ? acc.addr : 32'h0);
            checkOutput("mem_wdata", mem_wdata, have ? acc.data : 32'h0);
            exp_v0 = have && acc.lane == 0;
            exp_v1 = have && acc.lane == 1;
            if (have) begin
                if (acc.lane == 0) exp_rd0 = acc.we ? 32'h0 : model_mem[acc.addr[7:0]];
                else               exp_rd1 = acc.we ? 32'h0 : model_mem[acc.addr[7:0]];
                if (acc.we) model_mem[acc.addr[7:0]] = acc.data;
            end
        end
    end

    // Drive one cycle of inputs, then return just after the falling edge.
    task automatic applyStimulus(input logic v0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                                 input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                                 input logic fl);
        @(posedge clk); #1;
        req_valid_0 = v0; req_we_0 = we0; req_addr_0 = a0; req_wdata_0 = d0;
        req_valid_1 = v1; req_we_1 = we1; req_addr_1 = a1; req_wdata_1 = d1;
        flush = fl;
        @(negedge clk); #1;
    endtask

    task automatic idleCycle(input logic fl);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, fl);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i]   = 32'h0;
            model_mem[i] = 32'h0;
        end
        env_mem[8'h30]   = 32'h7;
        model_mem[8'h30] = 32'h7;
        rst = 0; flush = 0;
        req_valid_0 = 0; req_we_0 = 0; req_addr_0 = 0; req_wdata_0 = 0;
        req_valid_1 = 0; req_we_1 = 0; req_addr_1 = 0; req_wdata_1 = 0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_ready_0", 32'(req_ready_0), 32'h0);
        checkOutput("reset_rsp_valid_0", 32'(rsp_valid_0), 32'h0);
        @(posedge clk); #1;
        rst = 1;

        // Lone lane-0 store, then load back.
        applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0, 0);
        checkOutput("st_write_en", 32'(mem_write_en), 32'h1);
        checkOutput("st_ready_0", 32'(req_ready_0), 32'h1);
        applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        checkOutput("ld_read_en", 32'(mem_read_en), 32'h1);
        idleCycle(0);
        checkOutput("ld_rsp_valid_0", 32'(rsp_valid_0), 32'h1);
        checkOutput("ld_rsp_rdata_0", rsp_rdata_0, 32'hDEADBEEF);

        // Pair: lane-0 store then lane-1 load of the same address.
        applyStimulus(1, 1, 32'h20, 32'h5, 1, 0, 32'h20, 32'h0, 0);
        checkOutput("pair_ready_1", 32'(req_ready_1), 32'h1);
        checkOutput("pair_write_en", 32'(mem_write_en), 32'h1);
        idleCycle(0);
        checkOutput("hold_ready_0", 32'(req_ready_0), 32'h0);
        checkOutput("hold_ready_1", 32'(req_ready_1), 32'h0);
        checkOutput("hold_addr", mem_addr, 32'h20);
        checkOutput("hold_read_en", 32'(mem_read_en), 32'h1);
        idleCycle(0);
        checkOutput("pair_rsp_valid_1", 32'(rsp_valid_1), 32'h1);
        checkOutput("pair_rsp_rdata_1", rsp_rdata_1, 32'h5);

        // Pair: lane-0 load sees old data, lane-1 store lands afterwards.
        applyStimulus(1, 0, 32'h30, 32'h0, 1, 1, 32'h30, 32'h9, 0);
        idleCycle(0);
        checkOutput("war_rsp_rdata_0", rsp_rdata_0, 32'h7);
        checkOutput("war_wdata", mem_wdata, 32'h9);
        applyStimulus(1, 0, 32'h30, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        idleCycle(0);
        checkOutput("war_reload", rsp_rdata_0, 32'h9);

        // Flush in HOLD drops the buffered lane-1 store.
        applyStimulus(1, 0, 32'h10, 32'h0, 1, 1, 32'h50, 32'hAA, 0);
        idleCycle(1);
        checkOutput("flush_hold_write_en", 32'(mem_write_en), 32'h0);
        idleCycle(0);
        checkOutput("flush_rsp_valid_1", 32'(rsp_valid_1), 32'h0);
        applyStimulus(1, 0, 32'h50, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        idleCycle(0);
        checkOutput("flush_mem_untouched", rsp_rdata_0, 32'h0);

        // Flush in IDLE blocks issue.
        applyStimulus(1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0, 1);
        checkOutput("flush_idle_ready_0", 32'(req_ready_0), 32'h0);
        checkOutput("flush_idle_read_en", 32'(mem_read_en), 32'h0);

        // Lone lane-1 load.
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0, 0);
        idleCycle(0);
        checkOutput("l1_rsp_rdata_1", rsp_rdata_1, 32'h5);

        // Reset asserted mid-HOLD: outputs clear at once and the store never lands.
        applyStimulus(1, 0, 32'h10, 32'h0, 1, 1, 32'h40, 32'h1234, 0);
        @(posedge clk); #1;
        req_valid_0 = 0; req_valid_1 = 0; req_we_0 = 0; req_we_1 = 0;
        req_addr_0 = 0; req_addr_1 = 0; req_wdata_0 = 0; req_wdata_1 = 0;
        #2;
        rst = 0;
        #1;
        checkOutput("async_rst_rsp_valid_0", 32'(rsp_valid_0), 32'h0);
        checkOutput("async_rst_rsp_rdata_0", rsp_rdata_0, 32'h0);
        checkOutput("async_rst_write_en", 32'(mem_write_en), 32'h0);
        @(posedge clk); #1;
        rst = 1;
        applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        applyStimulus(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        checkOutput("pre_rdata_0", rsp_rdata_0, 32'hDEADBEEF);
        idleCycle(0);
        checkOutput("rst_store_dropped", rsp_rdata_0, 32'h0);

        // Three conflicting pairs, the second flushed in HOLD.
        applyStimulus(1, 0, 32'h20, 32'h0, 1, 0, 32'h10, 32'h0, 0);
        idleCycle(0);
        applyStimulus(1, 0, 32'h30, 32'h0, 1, 1, 32'h60, 32'h3, 0);
        idleCycle(1);
        applyStimulus(1, 1, 32'h70, 32'h11, 1, 0, 32'h70, 32'h0, 0);
        idleCycle(0);
        idleCycle(0);
        checkOutput("last_rsp_rdata_1", rsp_rdata_1, 32'h11);
`ifdef ARB_PERF_CNT_EN
        checkOutput("perf_conflict_cnt", conflict_cnt, 32'd3);
        checkOutput("perf_flush_drop_cnt", flush_drop_cnt, 32'd1);
`endif
        idleCycle(0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
